// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR pattern-generator slice.
//   - state_e        : sequencing controller states (HALT is only reachable
//                      when LFSR_SEQ_PERIOD_EN is defined)
//   - LFSR_RESET_VAL : value the shift register holds after reset
//   - LFSR_TAPS      : Fibonacci tap mask; feedback = XOR of (y & LFSR_TAPS)
//   - lfsr_next()    : one shift of the register
//   - lfsr_seed()    : maps a switch seed onto a legal (non-zero) LFSR value
// Optional feature macro used by this slice: LFSR_SEQ_PERIOD_EN.
package lfsr_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_RESET_VAL = 8'h01;
  localparam logic [7:0] LFSR_TAPS      = 8'b0001_1101;

  // New bit enters at the top and the register shifts towards bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {^(cur & LFSR_TAPS), cur[7:1]};
  endfunction

  // All-zero is the lock-up state of an XOR LFSR, so it is replaced.
  function automatic logic [7:0] lfsr_seed(input logic [7:0] sw);
    return (sw == 8'h00) ? LFSR_RESET_VAL : sw;
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_lfsr8.sv
// lfsr8: 8-bit Fibonacci shift register with synchronous load.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset (register -> LFSR_RESET_VAL)
//   en   in  advance one step this cycle
//   load in  load din this cycle (wins over en)
//   din  in  [7:0] load value (caller guarantees non-zero)
//   q    out [7:0] current register value
// Not affected by LFSR_SEQ_PERIOD_EN.
module lfsr8
  import lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (en) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= LFSR_RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: turns the run/step/load push buttons into an advance/load
// schedule for the 8-bit LFSR that drives the seven-segment display.
// Parameters:
//   TICK_DIV  clk cycles per advance while running (>= 2)
//   DIV_W     prescaler width, must hold TICK_DIV-1
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   btn_run       raw button; rising edge toggles RUN/PAUSE
//   btn_step      raw button; rising edge advances once while paused
//   btn_load      raw button; rising edge loads sw_seed
//   sw_seed [7:0] seed switches
//   y       [7:0] current LFSR value
//   step_cnt[7:0] advances since last load/reset (wraps)
//   running       high while in RUN
//   period_done   sticky full-period flag
// Macro LFSR_SEQ_PERIOD_EN: when defined, the controller remembers the seed
// and stops in HALT once the sequence returns to it; otherwise period_done
// is tied low and the LFSR free-runs.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000,
  parameter int DIV_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       btn_load,
  input  logic [7:0] sw_seed,
  output logic [7:0] y,
  output logic [7:0] step_cnt,
  output logic       running,
  output logic       period_done
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  // Bit order in the button vectors: [2]=load, [1]=step, [0]=run.
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] prev_q;
  logic [2:0] pulse;
  logic       run_p;
  logic       step_p;
  logic       load_p;

  state_e           state_q;
  state_e           state_d;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             running_q;
  logic             adv;
  logic [7:0]       seed_val;

  // Two-flop synchronizer plus the edge-history flop for all three buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {btn_load, btn_step, btn_run};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse    = sync2_q & ~prev_q;
  assign run_p    = pulse[0];
  assign step_p   = pulse[1];
  assign load_p   = pulse[2];
  assign seed_val = lfsr_seed(sw_seed);

`ifdef LFSR_SEQ_PERIOD_EN
  logic [7:0] seed_q;
  logic       done_q;
  logic       done_d;
`endif

  // Next-state logic. A load pre-empts everything else in its cycle, so any
  // coincident step, tick or run toggle is simply dropped.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
`ifdef LFSR_SEQ_PERIOD_EN
    done_d  = done_q;
`endif
    if (load_p) begin
      presc_d = '0;
      cnt_d   = 8'd0;
`ifdef LFSR_SEQ_PERIOD_EN
      done_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        PAUSE: begin
          if (run_p) begin
            state_d = RUN;
            presc_d = '0;
          end else if (step_p) begin
            adv = 1'b1;
          end
        end
        RUN: begin
          if (run_p) begin
            state_d = PAUSE;
            presc_d = '0;
          end else if (presc_q == TICK_LAST) begin
            adv     = 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
`ifdef LFSR_SEQ_PERIOD_EN
        HALT: begin
          if (run_p) begin
            state_d = RUN;
            presc_d = '0;
            done_d  = 1'b0;
          end
        end
`endif
        default: begin
          state_d = PAUSE;
          presc_d = '0;
        end
      endcase
      if (adv) begin
        cnt_d = cnt_q + 8'd1;
`ifdef LFSR_SEQ_PERIOD_EN
        // Returning to the seed means a full period has been shown; a manual
        // step flags it but stays paused, a free run stops in HALT.
        if (lfsr_next(y) == seed_q) begin
          done_d = 1'b1;
          if (state_q == RUN) begin
            state_d = HALT;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PAUSE;
      presc_q   <= '0;
      cnt_q     <= 8'd0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
    end
  end

`ifdef LFSR_SEQ_PERIOD_EN
  // Seed copy and sticky period flag only exist with the period feature.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q <= LFSR_RESET_VAL;
      done_q <= 1'b0;
    end else begin
      if (load_p) begin
        seed_q <= seed_val;
      end
      done_q <= done_d;
    end
  end

  assign period_done = done_q;
`else
  assign period_done = 1'b0;
`endif

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .load (load_p),
    .din  (seed_val),
    .q    (y)
  );

  assign step_cnt = cnt_q;
  assign running  = running_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: self-checking bench for lfsr_seq_ctrl with TICK_DIV=4.
// Expected LFSR values come from a parity-based reference of the feedback
// rule; RUN-mode advance counts are derived from elapsed cycles.
// Honours LFSR_SEQ_PERIOD_EN for the full-period scenario.
`timescale 1ns/1ps
module tb_lfsr_seq_ctrl;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnRun;
  logic       btnStep;
  logic       btnLoad;
  logic [7:0] swSeed;
  logic [7:0] y;
  logic [7:0] stepCnt;
  logic       running;
  logic       periodDone;

  int         checkCount = 0;
  int         passCount  = 0;
  int         failCount  = 0;
  logic [7:0] modelY;
  logic [7:0] modelCnt;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.TICK_DIV(TICK), .DIV_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run     (btnRun),
    .btn_step    (btnStep),
    .btn_load    (btnLoad),
    .sw_seed     (swSeed),
    .y           (y),
    .step_cnt    (stepCnt),
    .running     (running),
    .period_done (periodDone)
  );

  // Reference: new top bit is the parity of the tapped bits, rest shift down.
  function automatic logic [7:0] refAdvance(input logic [7:0] v, input int n);
    logic [7:0] r;
    int parity;
    r = v;
    for (int i = 0; i < n; i++) begin
      parity = $countones(r & 8'h1D) % 2;
      r = (r >> 1) | 8'(parity * 128);
    end
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic run, input logic step,
                               input logic load, input logic [7:0] seed);
    btnRun  = run;
    btnStep = step;
    btnLoad = load;
    swSeed  = seed;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount = checkCount + 1;
    assert (obs === exp) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step while paused, including the three-edge latency check.
  task automatic doStep();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    cycles(2);
    checkOutput("stepLatency", y, modelY);
    cycles(1);
    modelY   = refAdvance(modelY, 1);
    modelCnt = modelCnt + 8'd1;
    checkOutput("stepY", y, modelY);
    checkOutput("stepCnt", stepCnt, modelCnt);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    cycles(3);
  endtask

  task automatic doLoad(input logic [7:0] seed, input logic withStep);
    applyStimulus(1'b0, withStep, 1'b1, seed);
    cycles(3);
    modelY   = (seed == 8'h00) ? 8'h01 : seed;
    modelCnt = 8'd0;
    checkOutput("loadY", y, modelY);
    checkOutput("loadCnt", stepCnt, modelCnt);
    applyStimulus(1'b0, 1'b0, 1'b0, seed);
    cycles(3);
  endtask

  // Run for k cycles after entry, then pause. The pause press lands on edge
  // k+3 after entry and swallows a tick on that edge.
  task automatic doRun(input int k, input logic withStep);
    logic [7:0] y0;
    logic [7:0] c0;
    int n;
    y0 = modelY;
    c0 = modelCnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    cycles(3);
    checkOutput("runEnter", running, 1'b1);
    checkOutput("runEnterY", y, y0);
    applyStimulus(1'b0, withStep, 1'b0, 8'h00);
    cycles(k);
    n = k / TICK;
    checkOutput("runY", y, refAdvance(y0, n));
    checkOutput("runCnt", stepCnt, 8'(c0 + 8'(n)));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    cycles(3);
    n        = (k + 2) / TICK;
    modelY   = refAdvance(y0, n);
    modelCnt = 8'(c0 + 8'(n));
    checkOutput("pauseRunning", running, 1'b0);
    checkOutput("pauseY", y, modelY);
    checkOutput("pauseCnt", stepCnt, modelCnt);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    cycles(20);
    checkOutput("holdY", y, modelY);
    checkOutput("holdRunning", running, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    logic [7:0] seed;

    // Reset values.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    cycles(3);
    rst = 1'b0;
    modelY   = 8'h01;
    modelCnt = 8'd0;
    checkOutput("resetY", y, 8'h01);
    checkOutput("resetCnt", stepCnt, 8'd0);
    checkOutput("resetRunning", running, 1'b0);
    checkOutput("resetPeriod", periodDone, 1'b0);

    // Three manual steps from the reset value.
    for (int i = 0; i < 3; i++) doStep();
    checkOutput("threeStepsY", y, 8'h20);
    checkOutput("threeStepsCnt", stepCnt, 8'd3);

    // Zero seed is replaced, non-zero seed taken as is.
    doLoad(8'h00, 1'b0);
    doLoad(8'hA5, 1'b0);

    // Run/pause with a fixed duration, then with a step pressed mid-run.
    doRun(17, 1'b0);
    doRun(12, 1'b1);

    // Load and step rising together: only the load acts.
    doLoad(8'h3C, 1'b1);

    // Randomized mix of loads, steps and runs.
    for (int t = 0; t < 4; t++) begin
      seed = 8'($urandom);
      doLoad(seed, 1'($urandom_range(0, 1)));
      for (int s = 0; s < int'($urandom_range(1, 3)); s++) doStep();
      doRun(int'($urandom_range(5, 30)), 1'($urandom_range(0, 1)));
    end

    // Full period from seed 1.
    doLoad(8'h01, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    cycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
`ifdef LFSR_SEQ_PERIOD_EN
    waited = 0;
    while (running === 1'b1 && waited < 1100) begin
      cycles(1);
      waited++;
    end
    checkOutput("periodCycles", waited, 255 * TICK);
    checkOutput("periodY", y, 8'h01);
    checkOutput("periodDone", periodDone, 1'b1);
    checkOutput("periodCnt", stepCnt, 8'd255);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    cycles(3);
    checkOutput("haltToRun", running, 1'b1);
    checkOutput("haltClearDone", periodDone, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    cycles(5);
`else
    waited = 256 * TICK;
    cycles(waited);
    checkOutput("wrapCnt", stepCnt, 8'd0);
    checkOutput("wrapY", y, refAdvance(8'h01, 256));
    checkOutput("wrapRunning", running, 1'b1);
    checkOutput("wrapPeriod", periodDone, 1'b0);
`endif

    // Reset in RUN with a run pulse already in the synchronizer.
    cycles(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    cycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    cycles(1);
    checkOutput("midResetY", y, 8'h01);
    checkOutput("midResetCnt", stepCnt, 8'd0);
    checkOutput("midResetRunning", running, 1'b0);
    rst = 1'b0;
    cycles(6);
    checkOutput("afterResetRunning", running, 1'b0);
    checkOutput("afterResetY", y, 8'h01);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
